// File: rtl/alu_issue_stage.sv
// RV32I decode/issue stage: produces aluc and ALU operands, registered with a
// one-entry skid buffer on a valid/ready interface.
module alu_issue_stage #(
    parameter bit PASS_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs1_data,
    input  logic [31:0] in_rs2_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_aluc,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [4:0]  out_rd,
    output logic        out_illegal
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 4;
    localparam int unsigned RW   = 5;

    localparam logic [AW-1:0] ALU_ADD  = AW'(0);
    localparam logic [AW-1:0] ALU_SUB  = AW'(1);
    localparam logic [AW-1:0] ALU_AND  = AW'(2);
    localparam logic [AW-1:0] ALU_OR   = AW'(3);
    localparam logic [AW-1:0] ALU_XOR  = AW'(4);
    localparam logic [AW-1:0] ALU_SLL  = AW'(5);
    localparam logic [AW-1:0] ALU_SLT  = AW'(6);
    localparam logic [AW-1:0] ALU_SLTU = AW'(7);
    localparam logic [AW-1:0] ALU_SRL  = AW'(8);
    localparam logic [AW-1:0] ALU_SRA  = AW'(9);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [AW-1:0]   aluc;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [RW-1:0]   rd;
        logic            illegal;
    } issue_t;

    // funct3 -> aluc for the funct7=0000000 OP/OP-IMM group
    function automatic logic [AW-1:0] f3_aluc(input logic [2:0] f3);
        case (f3)
            3'd0:    return ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i, imm_s, imm_u, shamt_imm, shamt_reg;
    logic            ill;
    issue_t          dec;

    assign opcode    = in_instr[6:0];
    assign f3        = in_instr[14:12];
    assign f7        = in_instr[31:25];
    assign imm_i     = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s     = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_u     = {in_instr[31:12], 12'b0};
    assign shamt_imm = {27'b0, in_instr[24:20]};
    assign shamt_reg = {27'b0, in_rs2_data[4:0]};

    // Instruction decode; illegal encodings collapse to an all-zero payload
    always_comb begin
        dec = '0;
        ill = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec.a  = in_rs1_data;
                dec.rd = in_instr[11:7];
                dec.b  = (f3 == 3'b001 || f3 == 3'b101) ? shamt_reg : in_rs2_data;
                if (f7 == 7'h00)                      dec.aluc = f3_aluc(f3);
                else if (f7 == 7'h20 && f3 == 3'b000) dec.aluc = ALU_SUB;
                else if (f7 == 7'h20 && f3 == 3'b101) dec.aluc = ALU_SRA;
                else                                  ill      = 1'b1;
            end
            OPC_OPIMM: begin
                dec.a    = in_rs1_data;
                dec.rd   = in_instr[11:7];
                dec.aluc = f3_aluc(f3);
                dec.b    = imm_i;
                if (f3 == 3'b001) begin
                    dec.b = shamt_imm;
                    ill   = (f7 != 7'h00);
                end else if (f3 == 3'b101) begin
                    dec.b = shamt_imm;
                    if (f7 == 7'h20)      dec.aluc = ALU_SRA;
                    else if (f7 != 7'h00) ill      = 1'b1;
                end
            end
            OPC_LUI: begin
                dec.b  = imm_u;
                dec.rd = in_instr[11:7];
            end
            OPC_AUIPC: begin
                dec.a  = in_pc;
                dec.b  = imm_u;
                dec.rd = in_instr[11:7];
            end
            OPC_LOAD: begin
                dec.a  = in_rs1_data;
                dec.b  = imm_i;
                dec.rd = in_instr[11:7];
            end
            OPC_STORE: begin
                dec.a = in_rs1_data;
                dec.b = imm_s;
            end
            OPC_BRANCH: begin
                dec.a = in_rs1_data;
                dec.b = in_rs2_data;
                case (f3[2:1])
                    2'b00:   dec.aluc = ALU_SUB;
                    2'b10:   dec.aluc = ALU_SLT;
                    2'b11:   dec.aluc = ALU_SLTU;
                    default: ill      = 1'b1;
                endcase
            end
            default: ill = 1'b1;
        endcase
        if (ill) dec = '0;
        dec.illegal = ill;
    end

    issue_t main_q, skid_q;
    logic   main_valid, skid_valid;
    logic   keep, main_free;

    assign in_ready  = !skid_valid;
    assign keep      = in_valid && in_ready && (PASS_ILLEGAL || !dec.illegal);
    assign main_free = !main_valid || out_ready;

    // Main/skid pipeline registers; skid always refills main before new input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (main_free) begin
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= keep;
                if (keep) skid_q <= dec;
            end else if (keep) begin
                main_q     <= dec;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (keep) begin
            skid_q     <= dec;
            skid_valid <= 1'b1;
        end
    end

    assign out_valid   = main_valid;
    assign out_aluc    = main_q.aluc;
    assign out_a       = main_q.a;
    assign out_b       = main_q.b;
    assign out_rd      = main_q.rd;
    assign out_illegal = main_q.illegal;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vectors, illegal handling in both
// PASS_ILLEGAL modes, skid backpressure and asynchronous reset mid-stall.
module tb_alu_issue_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_instr, in_pc, in_rs1_data, in_rs2_data;
    logic        out_ready;

    logic        in_ready, out_valid, out_illegal;
    logic [3:0]  out_aluc;
    logic [31:0] out_a, out_b;
    logic [4:0]  out_rd;

    logic        p0_in_ready, p0_out_valid, p0_out_illegal;
    logic [3:0]  p0_out_aluc;
    logic [31:0] p0_out_a, p0_out_b;
    logic [4:0]  p0_out_rd;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.PASS_ILLEGAL(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_aluc(out_aluc),
        .out_a(out_a), .out_b(out_b), .out_rd(out_rd), .out_illegal(out_illegal)
    );

    alu_issue_stage #(.PASS_ILLEGAL(1'b0)) dut_drop (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(p0_in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .out_valid(p0_out_valid), .out_ready(out_ready), .out_aluc(p0_out_aluc),
        .out_a(p0_out_a), .out_b(p0_out_b), .out_rd(p0_out_rd), .out_illegal(p0_out_illegal)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [3:0] aluc,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] rd, input logic ill);
        check({tag, ".valid"},   32'(out_valid),   32'(v));
        check({tag, ".aluc"},    32'(out_aluc),    32'(aluc));
        check({tag, ".a"},       out_a,            a);
        check({tag, ".b"},       out_b,            b);
        check({tag, ".rd"},      32'(out_rd),      32'(rd));
        check({tag, ".illegal"}, 32'(out_illegal), 32'(ill));
    endtask

    task automatic present(input logic [31:0] instr, input logic [31:0] pc,
                           input logic [31:0] r1, input logic [31:0] r2);
        in_instr    = instr;
        in_pc       = pc;
        in_rs1_data = r1;
        in_rs2_data = r2;
        in_valid    = 1'b1;
    endtask

    // Single accepted beat with out_ready=1; outputs are sampled 1ns after the edge
    task automatic issue(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2);
        @(negedge clk);
        present(instr, pc, r1, r2);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_pc = '0; in_rs1_data = '0; in_rs2_data = '0;
        #12;
        expect_out("reset", 1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        check("reset.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk); rst_n = 1'b1;

        issue("add", 32'h002081B3, 32'h0, 32'd5, 32'd7);
        expect_out("add", 1'b1, 4'd0, 32'd5, 32'd7, 5'd3, 1'b0);
        check("add.drop_valid", 32'(p0_out_valid), 32'd1);
        issue("sub", 32'h402081B3, 32'h0, 32'd5, 32'd7);
        expect_out("sub", 1'b1, 4'd1, 32'd5, 32'd7, 5'd3, 1'b0);
        issue("srai", 32'h40315093, 32'h0, 32'h80000000, 32'd0);
        expect_out("srai", 1'b1, 4'd9, 32'h80000000, 32'd3, 5'd1, 1'b0);
        issue("sll", 32'h002091B3, 32'h0, 32'd4, 32'h00000021);
        expect_out("sll", 1'b1, 4'd5, 32'd4, 32'd1, 5'd3, 1'b0);
        issue("lui", 32'h123452B7, 32'h0, 32'hDEADBEEF, 32'd0);
        expect_out("lui", 1'b1, 4'd0, 32'd0, 32'h12345000, 5'd5, 1'b0);
        issue("auipc", 32'h00001097, 32'h00000400, 32'd9, 32'd0);
        expect_out("auipc", 1'b1, 4'd0, 32'h00000400, 32'h00001000, 5'd1, 1'b0);
        issue("addi_m1", 32'hFFF08093, 32'h0, 32'd10, 32'd0);
        expect_out("addi_m1", 1'b1, 4'd0, 32'd10, 32'hFFFFFFFF, 5'd1, 1'b0);
        issue("sw", 32'hFE20AE23, 32'h0, 32'h1000, 32'd3);
        expect_out("sw", 1'b1, 4'd0, 32'h1000, 32'hFFFFFFFC, 5'd0, 1'b0);
        issue("bltu", 32'h0020E463, 32'h0, 32'd1, 32'd2);
        expect_out("bltu", 1'b1, 4'd7, 32'd1, 32'd2, 5'd0, 1'b0);
        issue("br010", 32'h0020A463, 32'h0, 32'd1, 32'd2);
        expect_out("br010", 1'b1, 4'd0, 32'd0, 32'd0, 5'd0, 1'b1);
        issue("slli_f7", 32'h40109093, 32'h0, 32'd1, 32'd2);
        expect_out("slli_f7", 1'b1, 4'd0, 32'd0, 32'd0, 5'd0, 1'b1);
        issue("mul", 32'h022081B3, 32'h0, 32'd5, 32'd7);
        expect_out("mul", 1'b1, 4'd0, 32'd0, 32'd0, 5'd0, 1'b1);
        check("mul.drop_valid", 32'(p0_out_valid), 32'd0);
        @(posedge clk); #1;
        check("idle.valid", 32'(out_valid), 32'd0);

        // Backpressure: A to main, B to skid, C held upstream
        @(negedge clk);
        out_ready = 1'b0;
        present(32'h002081B3, 32'h0, 32'd1, 32'd2);
        @(posedge clk); #1;
        check("bp.ready_a", 32'(in_ready), 32'd1);
        @(negedge clk);
        present(32'h402081B3, 32'h0, 32'd10, 32'd3);
        @(posedge clk); #1;
        check("bp.ready_b", 32'(in_ready), 32'd0);
        @(negedge clk);
        present(32'h0020C1B3, 32'h0, 32'h000000F0, 32'h0000000F);
        @(posedge clk); #1;
        expect_out("bp.holdA", 1'b1, 4'd0, 32'd1, 32'd2, 5'd3, 1'b0);
        check("bp.ready_c", 32'(in_ready), 32'd0);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        expect_out("bp.B", 1'b1, 4'd1, 32'd10, 32'd3, 5'd3, 1'b0);
        check("bp.ready_after", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        expect_out("bp.C", 1'b1, 4'd4, 32'h000000F0, 32'h0000000F, 5'd3, 1'b0);
        @(posedge clk); #1;
        check("bp.empty", 32'(out_valid), 32'd0);

        // Async reset with skid full
        @(negedge clk);
        out_ready = 1'b0;
        present(32'h002081B3, 32'h0, 32'd1, 32'd2);
        @(posedge clk); #1;
        @(negedge clk);
        present(32'h402081B3, 32'h0, 32'd10, 32'd3);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("rst.skid_full", 32'(in_ready), 32'd0);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        expect_out("rst.mid", 1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        check("rst.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        issue("post_rst", 32'h002081B3, 32'h0, 32'd5, 32'd7);
        expect_out("post_rst", 1'b1, 4'd0, 32'd5, 32'd7, 5'd3, 1'b0);
        @(posedge clk); #1;
        check("post_rst.empty", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/issue pipeline stage that produces the 4-bit aluc opcode and both 32-bit ALU operands from an RV32I instruction plus register-file data.
- It is the driving end of the ALU interface: its outputs feed the ALU's aluc/a/b inputs directly.
- Registered, valid/ready handshaked on both sides with a one-entry skid buffer, so a future pipelined core can stall it without dropping instructions.

Parameters:
- PASS_ILLEGAL, 1, 1: forward undecodable instructions with out_illegal=1. 0: silently drop them (no output beat).

Ports:
- clk  input  1  clock, rising-edge
- rst_n  input  1  asynchronous reset, active-low
- in_valid  input  1  upstream instruction valid
- in_ready  output  1  stage can accept an instruction
- in_instr  input  32  instruction word
- in_pc  input  32  instruction address
- in_rs1_data  input  32  register-file read data for rs1
- in_rs2_data  input  32  register-file read data for rs2
- out_valid  output  1  issued operation valid
- out_ready  input  1  downstream (ALU/EX) accepts
- out_aluc  output  4  ALU opcode
- out_a  output  32  operand a
- out_b  output  32  operand b
- out_rd  output  5  destination register, instr[11:7]; 0 for STORE and BRANCH
- out_illegal  output  1  instruction not decodable by this stage

Behaviour:
- aluc encoding:
  - 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 slt, 7 sltu, 8 srl, 9 sra.
  - 10-15 are never emitted.
- OP (0110011):
  - funct7=0000000: funct3 0..7 maps to add, sll, slt, sltu, xor, srl, or, and.
  - funct7=0100000: funct3=000 gives sub, funct3=101 gives sra.
  - Any other funct7/funct3 combination is illegal.
  - a=rs1_data. b=rs2_data, except for shifts: b = {27'b0, rs2_data[4:0]}. The ALU shifts by the full b, so masking is mandatory.
- OP-IMM (0010011): same mapping with b = sign-extended I-imm (no sub).
  - SLLI/SRLI need funct7=0000000; SRAI needs 0100000; anything else is illegal.
  - Shift b = {27'b0, instr[24:20]}.
- LUI: aluc add, a=0, b={instr[31:12],12'b0}.
- AUIPC: aluc add, a=pc, b=U-imm.
- LOAD: aluc add, a=rs1, b=I-imm.
- STORE: aluc add, a=rs1, b=S-imm, rd=0.
- BRANCH: a=rs1, b=rs2, rd=0.
  - funct3 000/001 gives sub; 100/101 gives slt; 110/111 gives sltu.
  - funct3 010/011 is illegal.
- Illegal instruction, or any other opcode: aluc=0, a=0, b=0, rd=0, out_illegal=1.
  - Forwarded only if PASS_ILLEGAL=1; otherwise the stage accepts it and emits nothing.
- Pipeline:
  - Output register (main) plus one skid register.
  - Latency 1 cycle from accept (in_valid&&in_ready at edge N) to out_valid at N+1.
  - Throughput 1 per cycle while out_ready=1.
- in_ready = !skid_valid (registered, no combinational path from out_ready).
- Accept into main when main is empty or being drained this cycle. Otherwise accept into skid.
- When main drains and skid is valid, skid moves to main the same edge and skid empties.
- Simultaneous accept plus drain with skid valid: skid goes to main, the new input goes to skid.
- Outputs hold stable while out_valid && !out_ready.
- Order is strictly preserved.
- Reset (async, any time, including mid-stall):
  - out_valid=0, skid empty, in_ready=1.
  - out_aluc=0, out_a=0, out_b=0, out_rd=0, out_illegal=0.
  - In-flight instructions are discarded.

Test Plan:
- ADD 0x002081B3, rs1=5, rs2=7 -> next cycle out_valid=1, aluc=0, a=5, b=7, rd=3, illegal=0.
- SUB 0x402081B3 -> aluc=1. SRAI 0x40315093, rs1=0x80000000 -> aluc=9, b=3, rd=1.
- R-type SLL (funct3=001, funct7=0), rs2=0x00000021 -> aluc=5, b=1. LUI 0x123452B7 -> aluc=0, a=0, b=0x12345000, rd=5.
- BLTU 0x0020E463 -> aluc=7, rd=0. MUL 0x022081B3 -> illegal=1, aluc=0, a=b=0. With PASS_ILLEGAL=0, no out_valid beat for MUL.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles, three back-to-back in_valid instrs A,B,C.
  - Response: A in main, B in skid, in_ready=0 so C is held upstream.
  - After out_ready=1, outputs are A,B,C on consecutive cycles with no loss or duplication.
- Stall with skid full, then assert rst_n=0 mid-cycle -> out_valid and all outputs 0 immediately, in_ready=1. After release, a fresh ADD issues normally.
